// File: rtl/synth_env_pkg.sv
// Shared envelope definitions for the voice path stages (attack, decay,
// release).
//   env_state_e         : common envelope state encoding
//   SHIFT_MAX/SHIFT_MIN : attenuation shift limits (15 = silent, 0 = full)
//   BASE_PERIOD_DEFAULT : clocks per shift step at rate 0 (~3.9 ms @ 50 MHz)
package synth_env_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } env_state_e;

  localparam logic [3:0]  SHIFT_MAX           = 4'd15;
  localparam logic [3:0]  SHIFT_MIN           = 4'd0;
  localparam int unsigned BASE_PERIOD_DEFAULT = 195312;

endpackage

// File: rtl/attack_shift_amount_if.sv
// Envelope-stage bus between the envelope sequencer and the attack stage.
//   gate, attack_value : sequencer -> stage (note-on level, rate select)
//   shift_amount       : stage -> sequencer (attenuation shift)
//   busy, done         : stage -> sequencer (ramping / ramp finished)
// master = sequencer side, slave = attack stage side.
interface attack_shift_amount_if;
  logic       gate;
  logic [3:0] attack_value;
  logic [3:0] shift_amount;
  logic       busy;
  logic       done;

  modport master (
    output gate,
    output attack_value,
    input  shift_amount,
    input  busy,
    input  done
  );

  modport slave (
    input  gate,
    input  attack_value,
    output shift_amount,
    output busy,
    output done
  );
endinterface

// File: rtl/attack_step_timer.sv
// Step-period timer for the attack stage.
// Latches period = BASE_PERIOD * (attack_value + 1) on start_i and counts
// clocks while run_i is high, giving a one-cycle step_o every period.
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   start_i         : latch a new period and zero the counter
//   clear_i         : zero the counter (ignored when start_i is high)
//   run_i           : count enable
//   attack_value_i  : rate select, only used when start_i is high
//   step_o          : combinational tick on the last count of each period
module attack_step_timer #(
  parameter int unsigned BASE_PERIOD = 195312,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       run_i,
  input  logic [3:0] attack_value_i,
  output logic       step_o
);

  localparam logic [CNT_W-1:0] BASE_W = CNT_W'(BASE_PERIOD);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_cnt;

  // Product is at most 16*BASE_PERIOD, so CNT_W bits never overflow.
  assign last_cnt = (cnt_q == period_q - CNT_W'(1));
  assign step_o   = run_i && !clear_i && last_cnt;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      period_d = BASE_W * (CNT_W'(attack_value_i) + CNT_W'(1));
      cnt_d    = '0;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = last_cnt ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period_q <= BASE_W;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/attack_shift_amount.sv
// Attack-stage envelope generator: after a note-on, walks the attenuation
// shift from 15 (silent) down to 0 (full scale), one step per period, then
// reports done so the sequencer can hand over to decay.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   env (slave)  : gate, attack_value in; shift_amount, busy, done out
// Optional build macro ATTACK_INSTANT_EN: attack_value = 0 on note-on jumps
// straight to full scale (HOLD) without ramping.
//
// state | meaning
// IDLE  | no note; shift 15, waiting for a gate rising edge
// RAMP  | stepping shift down by one each period, busy high
// HOLD  | shift 0, done high until gate drops
module attack_shift_amount
  import synth_env_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = BASE_PERIOD_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  attack_shift_amount_if.slave   env
);

  env_state_e state_q;
  logic [3:0] shift_q;
  logic       busy_q;
  logic       done_q;
  logic       gate_q;
  logic       armed_q;
  logic       rise;
  logic       step;
  logic       tmr_start;
  logic       tmr_clear;
  logic       tmr_run;

  // armed_q keeps a gate that is held high across a reset from being seen
  // as a new note: gate must be observed low after reset before it can
  // start an attack.
  assign rise      = env.gate && !gate_q && armed_q;
  assign tmr_start = rise && (state_q == IDLE);
  assign tmr_run   = (state_q == RAMP);
  assign tmr_clear = (state_q != RAMP) || !env.gate;

  attack_step_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clock          (clock),
    .reset          (reset),
    .start_i        (tmr_start),
    .clear_i        (tmr_clear),
    .run_i          (tmr_run),
    .attack_value_i (env.attack_value),
    .step_o         (step)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= SHIFT_MAX;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      gate_q <= env.gate;
      if (!env.gate) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          shift_q <= SHIFT_MAX;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (rise) begin
`ifdef ATTACK_INSTANT_EN
            if (env.attack_value == 4'd0) begin
              state_q <= HOLD;
              shift_q <= SHIFT_MIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RAMP;
              busy_q  <= 1'b1;
            end
`else
            state_q <= RAMP;
            busy_q  <= 1'b1;
`endif
          end
        end

        RAMP: begin
          // Gate release wins over a step landing in the same cycle.
          if (!env.gate) begin
            state_q <= IDLE;
            shift_q <= SHIFT_MAX;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (step) begin
            if (shift_q == SHIFT_MIN + 4'd1) begin
              state_q <= HOLD;
              shift_q <= SHIFT_MIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              shift_q <= shift_q - 4'd1;
            end
          end
        end

        HOLD: begin
          if (!env.gate) begin
            state_q <= IDLE;
            shift_q <= SHIFT_MAX;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          shift_q <= SHIFT_MAX;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign env.shift_amount = shift_q;
  assign env.busy         = busy_q;
  assign env.done         = done_q;

endmodule

// File: tb/tb_attack_shift_amount.sv
// Directed bench for attack_shift_amount with BASE_PERIOD = 4.
module tb_attack_shift_amount;

  localparam int unsigned BASE = 4;
`ifdef ATTACK_INSTANT_EN
  localparam logic [3:0] AV_FAST = 4'd1;
  localparam int         P_FAST  = 8;
`else
  localparam logic [3:0] AV_FAST = 4'd0;
  localparam int         P_FAST  = 4;
`endif

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  attack_shift_amount_if env_if ();

  attack_shift_amount #(
    .BASE_PERIOD (BASE),
    .CNT_W       (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .env   (env_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_out(input string tag, input int sh, input int bz, input int dn);
    check({tag, ".shift"}, 32'(env_if.shift_amount), 32'(sh));
    check({tag, ".busy"},  32'(env_if.busy),         32'(bz));
    check({tag, ".done"},  32'(env_if.done),         32'(dn));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    env_if.gate = 1'b0;
    env_if.attack_value = 4'd0;
    cyc(3);
    check_out("reset", 15, 0, 0);
    reset = 1'b0;
    cyc(2);
    check_out("idle", 15, 0, 0);

`ifdef ATTACK_INSTANT_EN
    env_if.attack_value = 4'd0;
    env_if.gate = 1'b1;
    cyc(1);
    check_out("instant", 0, 0, 1);
    cyc(3);
    check_out("instant_hold", 0, 0, 1);
    env_if.gate = 1'b0;
    cyc(1);
    check_out("instant_rel", 15, 0, 0);
`endif

    // Fast ramp, period P_FAST.
    env_if.attack_value = AV_FAST;
    env_if.gate = 1'b1;
    cyc(1);
    check_out("p4_entry", 15, 1, 0);
    cyc(P_FAST - 1);
    check_out("p4_pre_step", 15, 1, 0);
    cyc(1);
    check_out("p4_first_step", 14, 1, 0);
    cyc(15 * P_FAST - P_FAST - 1);
    check_out("p4_last_ramp", 1, 1, 0);
    cyc(1);
    check_out("p4_done", 0, 0, 1);
    cyc(3);
    check_out("p4_hold", 0, 0, 1);

    // Release from HOLD.
    env_if.gate = 1'b0;
    cyc(1);
    check_out("hold_rel", 15, 0, 0);

    // Period 16; rate change mid-ramp is ignored.
    env_if.attack_value = 4'd3;
    env_if.gate = 1'b1;
    cyc(1);
    check_out("p16_entry", 15, 1, 0);
    cyc(15);
    check_out("p16_pre_step", 15, 1, 0);
    cyc(1);
    check_out("p16_first_step", 14, 1, 0);
    env_if.attack_value = 4'd0;
    cyc(16);
    check_out("p16_av_ignored", 13, 1, 0);
    cyc(207);
    check_out("p16_last_ramp", 1, 1, 0);
    cyc(1);
    check_out("p16_done", 0, 0, 1);

    // High->low->high on consecutive cycles restarts a full attack.
    env_if.attack_value = AV_FAST;
    env_if.gate = 1'b0;
    cyc(1);
    check_out("hlh_low", 15, 0, 0);
    env_if.gate = 1'b1;
    cyc(1);
    check_out("hlh_restart", 15, 1, 0);
    cyc(P_FAST);
    check_out("hlh_step", 14, 1, 0);

    // Gate drop on the exact cycle of a step tick.
    env_if.gate = 1'b0;
    cyc(1);
    env_if.gate = 1'b1;
    cyc(P_FAST);
    check_out("tick_pre", 15, 1, 0);
    env_if.gate = 1'b0;
    cyc(1);
    check_out("tick_rel", 15, 0, 0);

    // Release at shift 7, re-press two cycles later.
    env_if.gate = 1'b1;
    cyc(8 * P_FAST + 1);
    check_out("mid_shift7", 7, 1, 0);
    env_if.gate = 1'b0;
    cyc(1);
    check_out("mid_rel", 15, 0, 0);
    cyc(1);
    env_if.gate = 1'b1;
    cyc(1);
    check_out("re_entry", 15, 1, 0);
    cyc(15 * P_FAST - 1);
    check_out("re_last_ramp", 1, 1, 0);
    cyc(1);
    check_out("re_done", 0, 0, 1);

    // Reset mid-ramp with gate held high.
    env_if.gate = 1'b0;
    cyc(1);
    env_if.gate = 1'b1;
    cyc(2 * P_FAST + 2);
    check_out("rst_pre", 13, 1, 0);
    reset = 1'b1;
    cyc(1);
    check_out("rst_mid", 15, 0, 0);
    reset = 1'b0;
    cyc(20);
    check_out("rst_no_restart", 15, 0, 0);
    env_if.gate = 1'b0;
    cyc(1);
    env_if.gate = 1'b1;
    cyc(1);
    check_out("rst_new_attack", 15, 1, 0);
    cyc(15 * P_FAST);
    check_out("rst_attack_done", 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/attack_shift_amount.md
Name: attack_shift_amount

Overview:
Attack-stage envelope generator for the synthesizer voice path. It is the counterpart of the decay stage: decay raises the attenuation shift from 0 toward (15 - sustain), while this block lowers it from 15 (silent) to 0 (full scale) after a note-on. The step rate is selected by a 4-bit attack value. `done` tells the envelope sequencer to hand over to decay.

Parameters:
BASE_PERIOD, 195312, clock cycles per shift step when attack_value = 0 (about 3.9 ms at 50 MHz); must be >= 1.
CNT_W, 32, width of the step-period counter and period product.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
gate  input  1  note-on level; a rising edge starts an attack.
attack_value  input  4  attack rate select; sampled only on a gate rising edge.
shift_amount  output  4  attenuation shift applied to the sample (15 = quietest, 0 = loudest).
busy  output  1  high while ramping.
done  output  1  high while the attack has completed and gate is still high.

Behaviour:
- Reset (synchronous): state=IDLE, shift_amount=15, busy=0, done=0, step counter=0, gate_q=0, latched period=BASE_PERIOD.
- gate_q is a registered copy of gate. A rising edge is gate=1 and gate_q=0.
- Period latch on a rising edge: period = BASE_PERIOD * (attack_value + 1), computed in CNT_W bits. The product fits because it is at most 16*BASE_PERIOD.
- States:
  - IDLE: shift_amount=15, busy=0, done=0. A rising edge moves to RAMP on the next clock and clears the counter. shift_amount stays 15 on entry.
  - RAMP: busy=1. The counter increments each cycle. When counter == period-1, the counter returns to 0 and shift_amount decrements by 1. The decrement that reaches 0 also moves to HOLD in the same cycle.
  - HOLD: shift_amount=0, busy=0, done=1. Stays in HOLD while gate=1.
- Timing: the first decrement occurs `period` cycles after the RAMP entry edge. The 15→0 ramp lasts exactly 15*period cycles, then done asserts.
- Gate low in RAMP or HOLD returns to IDLE on the next clock: shift_amount=15, busy=0, done=0, counter=0. Gate low takes priority over a coincident step tick.
- Gate high→low→high across consecutive cycles is a fresh rising edge and starts a full 15-step attack.
- No wrap-around: shift_amount never decrements below 0 and never increments in RAMP.
- attack_value changes during RAMP are ignored until the next rising edge.
- Reset asserted mid-RAMP wins over everything and gives the reset values on the next edge.

Optional Feature:
ATTACK_INSTANT_EN
- Defined: attack_value=0 on a rising edge skips RAMP. The next clock goes directly to HOLD with shift_amount=0 and done=1; busy never asserts.
- Undefined: attack_value=0 ramps with period = BASE_PERIOD, like any other value.

Decomposition:
- Shared package synth_env_pkg holds:
  - the envelope state enum {IDLE, RAMP, HOLD}, shared with the decay/release stages;
  - constants SHIFT_MAX=4'd15 and SHIFT_MIN=4'd0;
  - the default BASE_PERIOD.
- One sub-module, attack_step_timer, contains the period latch/multiply and the counter. It outputs a one-cycle step tick and takes a clear input.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset, then BASE_PERIOD=4, attack_value=0, gate rises → first decrement 4 cycles after RAMP entry; shift reaches 0 after 60 cycles; done=1, busy=0.
- BASE_PERIOD=4, attack_value=3 → period 16; shift_amount=14 at cycle 16; done asserts after 240 cycles.
- Gate falls when shift_amount=7 → next cycle shift_amount=15, IDLE, busy=0; a gate rise 2 cycles later restarts a full 60-cycle ramp.
- attack_value changed from 3 to 0 mid-RAMP → period stays 16 until the attack completes.
- Reset pulsed mid-RAMP with gate held high → shift_amount=15 and IDLE; no new attack until gate goes low then high.
- With ATTACK_INSTANT_EN and attack_value=0 → shift_amount=0 and done=1 one cycle after the RAMP-entry edge; busy stays 0.
